dma_window_ctrl: RTL

Read-side controller for the accelerator's word-addressed feature/weight RAM. On a start pulse it fetches one K×K convolution window in row-major order and streams it to the PE loader over a valid/ready handshake. The block is the only master of the RAM's enable, read/write and address lines during a fetch. A 2-entry output buffer absorbs the RAM's 1-cycle read latency, so the stream runs at one word per cycle and tolerates consumer stalls without losing data.

---
 rtl/accel_pkg.sv | 18 +
 rtl/win_skid_fifo.sv | 66 ++++++
 rtl/dma_window_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator types: bus widths, word/address typedefs and the
// window-fetch FSM encoding.
package accel_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int KERNEL     = 5;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } win_state_e;

endpackage

// File: rtl/win_skid_fifo.sv
// Two-entry {data, idx} FIFO with fall-through when empty, so a RAM word can
// be presented in the cycle it returns.
module win_skid_fifo #(
  parameter int DW = 16,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic [IW-1:0] push_idx_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output logic [DW-1:0] head_data_o,
  output logic [IW-1:0] head_idx_o,
  output logic [1:0]    count_o
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } entry_t;

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       empty, full, wr_en, rd_en;
  entry_t     push_entry;

  always_comb begin
    empty      = (count_q == 2'd0);
    full       = (count_q == 2'd2);
    push_entry = '{data: push_data_i, idx: push_idx_i};
    // A word pushed into an empty FIFO and popped in the same cycle bypasses storage.
    wr_en      = push_i && !(empty && pop_i) && (!full || pop_i);
    rd_en      = pop_i && !empty;
    count_d    = count_q + 2'(wr_en) - 2'(rd_en);

    head_valid_o              = !empty || push_i;
    {head_data_o, head_idx_o} = (empty && push_i) ? push_entry : mem_q[rd_ptr_q];
    count_o                   = count_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset because its head drives win_data, which must read 0 out of reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dma_window_ctrl.sv
// Fetches one KxK window from the feature/weight RAM in row-major order and
// streams it over valid/ready at one word per cycle.
module dma_window_ctrl #(
  parameter  int ADDR_WIDTH = accel_pkg::ADDR_WIDTH,
  parameter  int DATA_WIDTH = accel_pkg::DATA_WIDTH,
  parameter  int KERNEL     = accel_pkg::KERNEL,
  localparam int IDX_W      = $clog2(KERNEL * KERNEL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [DATA_WIDTH-1:0] win_data,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  win_last
);

  import accel_pkg::*;

  localparam int                WORDS    = KERNEL * KERNEL;
  localparam int                CW       = $clog2(KERNEL);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CW-1:0]     EDGE_MAX = CW'(KERNEL - 1);

  win_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CW-1:0]         row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]      issue_q, issue_d;
  logic [IDX_W-1:0]      rsp_idx_q, rsp_idx_d;
  logic                  inflight_q, done_q, done_d;

  logic [1:0] fifo_count;
  logic [2:0] occ;
  logic       pop, issue_ok, issue, last_issue;

  // Issue only while buffered + in-flight words, net of this cycle's pop,
  // leave room for the response.
  always_comb begin
    pop        = win_valid && win_ready;
    occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    issue_ok   = (occ < 3'd2);
    issue      = (state_q == FETCH) && issue_ok;
    last_issue = (row_q == EDGE_MAX) && (col_q == EDGE_MAX);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    row_d     = row_q;
    col_d     = col_q;
    issue_d   = issue_q;
    rsp_idx_d = rsp_idx_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          addr_d   = base_addr;
          stride_d = row_stride;
          row_d    = '0;
          col_d    = '0;
          issue_d  = '0;
        end
      end
      FETCH: begin
        if (issue) begin
          rsp_idx_d = issue_q;
          issue_d   = issue_q + 1'b1;
          if (col_q == EDGE_MAX) begin
            col_d  = '0;
            row_d  = row_q + 1'b1;
            addr_d = addr_q + stride_q - ADDR_WIDTH'(KERNEL - 1);
          end else begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 1'b1;
          end
          if (last_issue) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && win_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      issue_q    <= '0;
      rsp_idx_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      row_q      <= row_d;
      col_q      <= col_d;
      issue_q    <= issue_d;
      rsp_idx_q  <= rsp_idx_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  win_skid_fifo #(
    .DW (DATA_WIDTH),
    .IW (IDX_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (inflight_q),
    .push_data_i  (mem_rdata),
    .push_idx_i   (rsp_idx_q),
    .pop_i        (pop),
    .head_valid_o (win_valid),
    .head_data_o  (win_data),
    .head_idx_o   (win_idx),
    .count_o      (fifo_count)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign mem_en   = issue;
  assign mem_rw   = 1'b1;
  assign mem_addr = addr_q;
  assign win_last = win_valid && (win_idx == LAST_IDX);

endmodule
